// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed 7-segment display blocks.
// All segment patterns are {G,F,E,D,C,B,A}, active-low.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Entry 15 first so SEG_TABLE[v] selects the pattern for value v; 7 keeps segment F lit.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h58, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Purpose: 4-bit value to active-low 7-segment pattern; decimal-only mode blanks 10-15.
// Latency: combinational.
// Backpressure: none.
module seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[value];
        if (!hex_mode && (value > 4'd9)) begin
            seg = SEG_OFF;
        end
    end

endmodule

// File: rtl/seven_seg_scan8.sv
// Purpose: scans eight snapshotted digits onto shared segments and eight anodes, with a blank gap per slot.
// Latency: outputs registered from next-state values; new inputs appear only after the next frame snapshot.
// Backpressure: none; free-running scan.
module seven_seg_scan8
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits,
    input  logic [7:0]  dp,
    input  logic [7:0]  en_mask,
    input  logic        hex_mode,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [7:0]  an,
    output logic        frame_start
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);

    logic [TW-1:0] tick_cnt;
    logic [2:0]    idx;
    scan_state_t   state;
    logic          load_pend;

    logic [31:0]   digits_s;
    logic [7:0]    dp_s;
    logic [7:0]    en_mask_s;
    logic          hex_mode_s;

    logic          slot_end;
    logic          snap;
    logic [TW-1:0] tick_nxt;
    logic [2:0]    idx_nxt;
    scan_state_t   state_nxt;
    logic [31:0]   digits_nxt;
    logic [7:0]    dp_nxt;
    logic [7:0]    en_mask_nxt;
    logic          hex_mode_nxt;
    logic [3:0]    digit_val;
    logic [6:0]    dec_seg;
    logic [7:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_n_nxt;

    assign slot_end = (tick_cnt == TICK_LAST);
    assign tick_nxt = slot_end ? '0 : tick_cnt + TW'(1);
    assign idx_nxt  = slot_end ? idx + 3'd1 : idx;

    // Snapshot on the 7->0 wrap so a frame always shows one coherent input set.
    assign snap = load_pend || (slot_end && (idx == 3'd7));

    assign digits_nxt   = snap ? digits   : digits_s;
    assign dp_nxt       = snap ? dp       : dp_s;
    assign en_mask_nxt  = snap ? en_mask  : en_mask_s;
    assign hex_mode_nxt = snap ? hex_mode : hex_mode_s;

    always_comb begin
        state_nxt = state;
        if (slot_end) begin
            state_nxt = BLANK;
        end else if ((state == BLANK) && (tick_cnt == BLANK_LAST)) begin
            state_nxt = DRIVE;
        end
    end

    assign digit_val = digits_nxt[{idx_nxt, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .value    (digit_val),
        .hex_mode (hex_mode_nxt),
        .seg      (dec_seg)
    );

    always_comb begin
        an_nxt   = AN_OFF;
        seg_nxt  = SEG_OFF;
        dp_n_nxt = 1'b1;
        if ((state_nxt == DRIVE) && en_mask_nxt[idx_nxt]) begin
            an_nxt   = ~(8'h01 << idx_nxt);
            seg_nxt  = dec_seg;
            dp_n_nxt = ~dp_nxt[idx_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt    <= '0;
            idx         <= 3'd0;
            state       <= BLANK;
            load_pend   <= 1'b1;
            digits_s    <= '0;
            dp_s        <= '0;
            en_mask_s   <= '0;
            hex_mode_s  <= 1'b0;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            tick_cnt    <= tick_nxt;
            idx         <= idx_nxt;
            state       <= state_nxt;
            load_pend   <= 1'b0;
            digits_s    <= digits_nxt;
            dp_s        <= dp_nxt;
            en_mask_s   <= en_mask_nxt;
            hex_mode_s  <= hex_mode_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp_n        <= dp_n_nxt;
            frame_start <= snap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan8.sv
// Directed table-driven bench for seven_seg_scan8 with an 8-cycle slot and 2-cycle blank gap.
module tb_seven_seg_scan8;

    logic        clk;
    logic        rst;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  en_mask;
    logic        hex_mode;
    logic [6:0]  seg;
    logic        dp_n;
    logic [7:0]  an;
    logic        frame_start;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic        hex;
        logic [63:0] seg;   // expected pattern per slot, slot 7 in the top byte
        bit          mid;   // change digits to 88888888 at the start of slot 3
    } vec_t;

    vec_t vecs[8];

    seven_seg_scan8 #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp          (dp),
        .en_mask     (en_mask),
        .hex_mode    (hex_mode),
        .seg         (seg),
        .dp_n        (dp_n),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        digits   = v.digits;
        dp       = v.dp;
        en_mask  = v.en;
        hex_mode = v.hex;
    endtask

    task automatic wait_frame(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 200);
        if (!frame_start) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_timeout: got no frame_start want frame_start within 200 cycles");
        end
    endtask

    // Called on the negedge where frame_start is high (slot 0, cycle 0).
    task automatic check_frame(input int vi, input vec_t v);
        int s;
        int t;
        bit act;
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) @(negedge clk);
            s   = c / 8;
            t   = c % 8;
            act = (t >= 2) && v.en[s];
            ea  = act ? ~(8'h01 << s) : 8'hFF;
            es  = act ? v.seg[s*8 +: 7] : 7'h7F;
            ed  = act ? ~v.dp[s] : 1'b1;
            chk($sformatf("v%0d c%0d an", vi, c), an, ea);
            chk($sformatf("v%0d c%0d seg", vi, c), seg, es);
            chk($sformatf("v%0d c%0d dp_n", vi, c), dp_n, ed);
            chk($sformatf("v%0d c%0d frame_start", vi, c), frame_start, (c == 0));
            if (v.mid && c == 24) digits = 32'h88888888;
        end
    endtask

    initial begin
        int k;
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{32'h76543210, 8'h00, 8'hFF, 1'b1, 64'h58_02_12_19_30_24_79_40, 1'b1};
        vecs[1] = '{32'h88888888, 8'h00, 8'hFF, 1'b1, 64'h00_00_00_00_00_00_00_00, 1'b0};
        vecs[2] = '{32'h000000A5, 8'h00, 8'h0F, 1'b0, 64'h7F_7F_7F_7F_40_40_7F_12, 1'b0};
        vecs[3] = '{32'h000000A5, 8'h00, 8'h0F, 1'b1, 64'h7F_7F_7F_7F_40_40_08_12, 1'b0};
        vecs[4] = '{32'h76543210, 8'h04, 8'hFF, 1'b1, 64'h58_02_12_19_30_24_79_40, 1'b0};
        vecs[5] = '{32'hFEDCBA98, 8'h00, 8'hFF, 1'b1, 64'h0E_06_21_46_03_08_10_00, 1'b0};
        vecs[6] = '{32'hFEDCBA98, 8'hA0, 8'hF0, 1'b0, 64'h7F_7F_7F_7F_7F_7F_7F_7F, 1'b0};
        vecs[7] = '{32'h76543210, 8'hFF, 8'h55, 1'b1, 64'h7F_02_7F_19_7F_24_7F_40, 1'b0};

        rst = 1'b0;
        apply(vecs[0]);

        repeat (3) @(negedge clk);
        chk("rst an", an, 8'hFF);
        chk("rst seg", seg, 7'h7F);
        chk("rst dp_n", dp_n, 1'b1);
        chk("rst frame_start", frame_start, 1'b0);

        rst = 1'b1;
        @(negedge clk);
        chk("post_rst frame_start", frame_start, 1'b1);
        chk("post_rst an_blank", an, 8'hFF);
        @(negedge clk);
        chk("first_drive frame_start", frame_start, 1'b0);
        chk("first_drive an", an, 8'hFE);
        chk("first_drive seg", seg, 7'h40);

        for (int vi = 0; vi < 8; vi++) begin
            apply(vecs[vi]);
            wait_frame(k);
            chk($sformatf("v%0d frame_gap", vi), k, (vi == 0) ? 62 : 1);
            check_frame(vi, vecs[vi]);
        end

        // Asynchronous reset while slot 5 is being driven.
        apply(vecs[4]);
        wait_frame(k);
        repeat (44) @(negedge clk);
        chk("pre_rst slot5 an", an, 8'hDF);
        #1 rst = 1'b0;
        #1;
        chk("async_rst an", an, 8'hFF);
        chk("async_rst seg", seg, 7'h7F);
        chk("async_rst dp_n", dp_n, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("restart frame_start", frame_start, 1'b1);
        chk("restart an_blank", an, 8'hFF);
        @(negedge clk);
        chk("restart an", an, 8'hFE);
        chk("restart seg", seg, 7'h40);
        chk("restart frame_start_low", frame_start, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
